// File: rtl/hazard_pkg.sv
// Shared widths and Tuse/Tnew encodings for the D-stage hazard scoreboard.
// Default parameter values for the scoreboard and the MDU busy counter live here too.
package hazard_pkg;

   localparam int unsigned NUM_REGS_DEF    = 32;
   localparam int unsigned TW_DEF          = 2;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   localparam logic [TW_DEF-1:0] TUSE_NONE = '1;
   localparam logic [TW_DEF-1:0] TNEW_ZERO = 2'd0;
   localparam logic [TW_DEF-1:0] TNEW_CAL  = 2'd1;
   localparam logic [TW_DEF-1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/mdu_busy_counter.sv
// MDU busy countdown: reloads on an issuing mult/div and counts down to zero otherwise.
// The reload is one longer than the MDU latency to cover the start cycle in E.
module mdu_busy_counter
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic issue_i,
   input  logic start_i,
   input  logic div_i,
   output logic busy_o
);

   localparam int unsigned MW = $clog2(DIV_CYCLES + 2);

   logic [MW-1:0] mcnt_d, mcnt_q;

   // A forced start while busy simply reloads.
   always_comb begin
      mcnt_d = mcnt_q;
      if (issue_i && start_i) begin
         mcnt_d = div_i ? MW'(DIV_CYCLES + 1) : MW'(MULT_CYCLES + 1);
      end else if (mcnt_q != '0) begin
         mcnt_d = mcnt_q - MW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt_q <= '0;
      end else begin
         mcnt_q <= mcnt_d;
      end
   end

   assign busy_o = (mcnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall unit: per-register Tnew countdown scoreboard plus MDU busy tracking.
// All outputs are combinational from the D-stage inputs and the registered countdowns.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
   parameter int unsigned TW          = TW_DEF,
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        D_valid,
   input  logic [$clog2(NUM_REGS)-1:0] D_rs,
   input  logic [$clog2(NUM_REGS)-1:0] D_rt,
   input  logic [TW-1:0]               D_rs_tuse,
   input  logic [TW-1:0]               D_rt_tuse,
   input  logic                        D_we,
   input  logic [$clog2(NUM_REGS)-1:0] D_A3,
   input  logic [TW-1:0]               D_tnew,
   input  logic                        D_mdu_use,
   input  logic                        D_mdu_start,
   input  logic                        D_mdu_div,
   output logic                        stall,
   output logic                        stall_data,
   output logic                        stall_mdu,
   output logic                        mdu_busy
);

   localparam int unsigned RW = $clog2(NUM_REGS);

   logic [TW-1:0] cnt_d [NUM_REGS];
   logic [TW-1:0] cnt_q [NUM_REGS];

   logic          issue;
   logic [TW-1:0] rs_cnt, rt_cnt;
   logic          stall_rs, stall_rt;

   assign issue = D_valid & ~stall;

   // Register 0 always reads as never pending.
   assign rs_cnt = (D_rs == '0) ? '0 : cnt_q[D_rs];
   assign rt_cnt = (D_rt == '0) ? '0 : cnt_q[D_rt];

   assign stall_rs   = D_valid & (D_rs != '0) & (rs_cnt > D_rs_tuse);
   assign stall_rt   = D_valid & (D_rt != '0) & (rt_cnt > D_rt_tuse);
   assign stall_data = stall_rs | stall_rt;
   assign stall_mdu  = D_valid & D_mdu_use & mdu_busy;
   assign stall      = stall_data | stall_mdu;

   // Newest writer overwrites any older countdown; the load beats the decrement.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - TW'(1) : '0;
         if (issue && D_we && (D_A3 == RW'(r))) begin
            cnt_d[r] = D_tnew;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   mdu_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu_busy_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .issue_i (issue),
      .start_i (D_mdu_start),
      .div_i   (D_mdu_div),
      .busy_o  (mdu_busy)
   );

endmodule
